// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load, strobe-timed bits,
// selectable bit order, idle line level and back-to-back reload.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1,
  parameter int CW         = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CE,
  input  logic [WIDTH-1:0] PI,
  input  logic             VALID,
  output logic             READY,
  input  logic             SI,
  output logic             O,
  output logic             BUSY,
  output logic             DONE,
  output logic [CW-1:0]    COUNT
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             done_nxt;
  logic             last_bit;
  logic             load;

  // Move the register one place toward the output end, SI entering behind.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic s);
    if (LSB_FIRST) shift_in = {s, v[WIDTH-1:1]};
    else           shift_in = {v[WIDTH-2:0], s};
  endfunction

  assign last_bit = (state == SHIFT) && CE && (cnt == LAST);
  assign READY    = RESETN && ((state == IDLE) || last_bit);
  assign load     = VALID && READY;

  assign O     = (state == SHIFT) ? (LSB_FIRST ? shreg[0] : shreg[WIDTH-1])
                                  : IDLE_LEVEL;
  assign BUSY  = (state == SHIFT);
  assign COUNT = cnt;

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    if (load) begin
      // A reload on the last-bit edge still reports completion of the old word.
      shreg_nxt = PI;
      cnt_nxt   = '0;
      state_nxt = SHIFT;
      done_nxt  = last_bit;
    end else if ((state == SHIFT) && CE) begin
      shreg_nxt = shift_in(shreg, SI);
      if (cnt == LAST) begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      DONE  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: 8-bit LSB-first, 4-bit MSB-first with
// fill, and 4-bit LSB-first back-to-back instances sharing clock and reset.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic       si = 1'b0;

  logic [7:0] pi8 = '0;
  logic       valid8 = 1'b0;
  logic       ready8, o8, busy8, done8;
  logic [2:0] count8;

  logic [3:0] pi4m = '0;
  logic       valid4m = 1'b0;
  logic       ready4m, o4m, busy4m, done4m;
  logic [1:0] count4m;

  logic [3:0] pi4l = '0;
  logic       valid4l = 1'b0;
  logic       ready4l, o4l, busy4l, done4l;
  logic [1:0] count4l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u8 (
    .CLK(clk), .RESETN(rst_n), .CE(ce), .PI(pi8), .VALID(valid8),
    .READY(ready8), .SI(si), .O(o8), .BUSY(busy8), .DONE(done8),
    .COUNT(count8));

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u4m (
    .CLK(clk), .RESETN(rst_n), .CE(ce), .PI(pi4m), .VALID(valid4m),
    .READY(ready4m), .SI(si), .O(o4m), .BUSY(busy4m), .DONE(done4m),
    .COUNT(count4m));

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u4l (
    .CLK(clk), .RESETN(rst_n), .CE(ce), .PI(pi4l), .VALID(valid4l),
    .READY(ready4l), .SI(si), .O(o4l), .BUSY(busy4l), .DONE(done4l),
    .COUNT(count4l));

  // exp holds the bits in transmission order, first-sent bit at exp[7].
  typedef struct {
    logic [7:0] pi;
    logic [7:0] exp;
    bit         ce_on_load;
    bit         mid_valid;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends one word through u8 with a CE every 4 cycles.
  task automatic send8(input vec_t v);
    pi8    = v.pi;
    valid8 = 1'b1;
    ce     = v.ce_on_load;
    #1;
    chk("ready8_idle", ready8, 1);
    tick();
    valid8 = 1'b0;
    ce     = 1'b0;
    chk("busy8_after_load", busy8, 1);
    chk("count8_after_load", count8, 0);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (v.mid_valid && k == 2 && c == 0) begin
          valid8 = 1'b1;
          pi8    = 8'hFF;
        end
        if (v.mid_valid && k == 5 && c == 0) begin
          valid8 = 1'b0;
          pi8    = v.pi;
        end
        if (c == 3) ce = 1'b1;
        #1;
        if (c == 0 || c == 3) begin
          chk("o8_bit", o8, v.exp[7-k]);
          chk("count8_bit", count8, k);
        end
        if (c == 3) chk("ready8_ce", ready8, (k == 7));
        else if (valid8) chk("ready8_midword", ready8, 0);
        tick();
        ce = 1'b0;
      end
      if (k < 7) chk("done8_early", done8, 0);
      else begin
        chk("done8_pulse", done8, 1);
        chk("busy8_end", busy8, 0);
        chk("o8_idle_end", o8, 1);
        chk("count8_end", count8, 0);
      end
    end
    tick();
    chk("done8_single", done8, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] seq;
    vecs[0] = '{pi: 8'hA5, exp: 8'hA5, ce_on_load: 1'b0, mid_valid: 1'b0};
    vecs[1] = '{pi: 8'h01, exp: 8'h80, ce_on_load: 1'b1, mid_valid: 1'b0};
    vecs[2] = '{pi: 8'hF0, exp: 8'h0F, ce_on_load: 1'b0, mid_valid: 1'b1};
    vecs[3] = '{pi: 8'h6D, exp: 8'hB6, ce_on_load: 1'b0, mid_valid: 1'b0};

    // Reset values, with VALID high to show READY is forced low.
    valid8 = 1'b1;
    tick();
    tick();
    chk("rst_o8", o8, 1);
    chk("rst_busy8", busy8, 0);
    chk("rst_ready8", ready8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_count8", count8, 0);
    valid8 = 1'b0;
    rst_n  = 1'b1;
    tick();
    chk("ready8_after_rst", ready8, 1);
    chk("o8_after_rst", o8, 1);

    // CE while idle changes nothing.
    for (int i = 0; i < 3; i++) begin
      ce = 1'b1;
      tick();
      chk("idle_ce_count8", count8, 0);
      chk("idle_ce_o8", o8, 1);
      chk("idle_ce_busy8", busy8, 0);
      chk("idle_ce_done8", done8, 0);
    end
    ce = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) send8(vecs[i]);

    // MSB-first with SI=1 fill on the 4-bit instance, CE every 2 cycles.
    si      = 1'b1;
    seq     = 8'b0000_0110;
    pi4m    = 4'b0110;
    valid4m = 1'b1;
    tick();
    valid4m = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("o4m_bit", o4m, seq[3-k]);
      tick();
      ce = 1'b1;
      tick();
      ce = 1'b0;
    end
    chk("done4m_pulse", done4m, 1);
    chk("busy4m_end", busy4m, 0);
    chk("o4m_idle", o4m, 1);
    chk("shreg4m_fill", u4m.shreg, 4'hF);
    si = 1'b0;
    tick();

    // Back-to-back reload on the 4-bit LSB-first instance.
    seq     = 8'b1100_0011;
    pi4l    = 4'h3;
    valid4l = 1'b1;
    #1;
    chk("ready4l_idle", ready4l, 1);
    tick();
    pi4l = 4'hC;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 3) ce = 1'b1;
        #1;
        if (c == 0) chk("o4l_bit", o4l, seq[7-k]);
        chk("ready4l", ready4l, (c == 3) && (k == 3 || k == 7));
        tick();
        ce = 1'b0;
      end
      if (k == 3) begin
        chk("done4l_reload", done4l, 1);
        chk("busy4l_reload", busy4l, 1);
        chk("count4l_reload", count4l, 0);
        valid4l = 1'b0;
      end else if (k == 7) begin
        chk("done4l_end", done4l, 1);
        chk("busy4l_end", busy4l, 0);
        chk("o4l_idle", o4l, 1);
      end else begin
        chk("done4l_mid", done4l, 0);
      end
    end
    tick();

    // Reset in the middle of a word, then a fresh word from bit 0.
    pi8    = 8'hA5;
    valid8 = 1'b1;
    tick();
    valid8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
      tick();
      ce = 1'b1;
      tick();
      ce = 1'b0;
    end
    chk("count8_pre_rst", count8, 3);
    chk("o8_pre_rst", o8, 0);
    valid8 = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_o8", o8, 1);
    chk("midrst_busy8", busy8, 0);
    chk("midrst_ready8", ready8, 0);
    chk("midrst_done8", done8, 0);
    chk("midrst_count8", count8, 0);
    tick();
    tick();
    chk("midrst_no_done", done8, 0);
    valid8 = 1'b0;
    rst_n  = 1'b1;
    tick();
    chk("midrst_done_after", done8, 0);
    chk("midrst_ready_after", ready8, 1);
    send8(vecs[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out shifter with a valid/ready load handshake, selectable bit order and an idle line level. It sits between a parallel word source and a single-bit output pin. Bit timing comes from an external strobe CE, typically the carry-out of a free-running prescaler counter. Compared with the fixed 4-bit PISO, it adds:
- a bit counter,
- busy/done status,
- back-to-back reload with no idle gap,
- a defined line level when no word is being sent.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = PI[0] is sent first; 0 = PI[WIDTH-1] is sent first.
- IDLE_LEVEL, 1, value driven on O while idle and during reset.
- CW, clog2(WIDTH), width of COUNT; derived, do not override.

Ports:
- CLK  in  1  rising-edge clock.
- RESETN  in  1  asynchronous active-low reset.
- CE  in  1  bit strobe; one-cycle pulse marks the end of a bit period.
- PI  in  WIDTH  parallel word; sampled when VALID and READY are both high.
- VALID  in  1  source has a word on PI.
- READY  out  1  block accepts PI on this edge (combinational).
- SI  in  1  fill bit shifted in behind the outgoing data.
- O  out  1  serial data out.
- BUSY  out  1  high while a word is being shifted.
- DONE  out  1  one-cycle pulse after the last bit of a word completes.
- COUNT  out  CW  number of bits of the current word already completed.

Behaviour:
- State machine: two states, IDLE and SHIFT.
  - Internal registers: shreg[WIDTH-1:0], cnt[CW-1:0], state, DONE.
- Reset (RESETN low, asynchronous):
  - state=IDLE, shreg=0, cnt=0, DONE=0.
  - READY forced 0 while RESETN is low.
  - O=IDLE_LEVEL, BUSY=0, COUNT=0.
  - A reset mid-word aborts the word with no DONE pulse.
- READY (combinational) = RESETN & ((state==IDLE) | (state==SHIFT & CE & cnt==WIDTH-1)).
- Load (VALID & READY at a rising edge):
  - shreg<=PI, cnt<=0, state<=SHIFT.
  - CE is not required for a load.
- O (combinational from registers):
  - SHIFT: LSB_FIRST ? shreg[0] : shreg[WIDTH-1].
  - IDLE: IDLE_LEVEL.
  - The first bit appears on O the cycle after the load edge.
- SHIFT with CE=1 and cnt<WIDTH-1:
  - shreg shifts one position toward the output end; SI fills the vacated end.
  - cnt<=cnt+1.
- SHIFT with CE=1 and cnt==WIDTH-1 (last bit ends):
  - DONE<=1 for exactly one cycle.
  - If VALID: reload from PI in the same edge; state stays SHIFT; O carries the new word's first bit with zero idle cycles.
  - Else: state<=IDLE, cnt<=0.
- SHIFT with CE=0: all state holds.
- VALID while SHIFT and not on the last-bit edge: ignored (READY=0). The source must hold VALID and PI stable until accepted.
- CE while IDLE: ignored; shreg and cnt hold.
- BUSY = (state==SHIFT). COUNT = cnt.
- Bit period:
  - Bit 0 lasts from the load edge to the next CE. The caller aligns VALID with CE when exact first-bit timing matters.
  - Bits 1..WIDTH-1 each last one CE period.
- Width rules:
  - cnt never exceeds WIDTH-1; there is no wrap past WIDTH-1.
  - COUNT for WIDTH=8 is 3 bits, with values 0..7.
- Simultaneous events:
  - Load and CE on the same idle edge: the load wins and the CE is ignored, so cnt=0.
  - Reset overrides everything.
- No combinational path from PI or SI to O.

Test Plan:
- Reset value: with WIDTH=8, IDLE_LEVEL=1, hold RESETN=0 -> O=1, BUSY=0, READY=0, DONE=0, COUNT=0. Release -> READY=1 on the next cycle.
- LSB-first word: WIDTH=8, LSB_FIRST=1, load PI=0xA5, CE every 4 cycles -> O sequence 1,0,1,0,0,1,0,1. COUNT steps 0..7. DONE pulses once after the 8th CE. Then BUSY=0 and O=1.
- MSB-first word with fill: WIDTH=4, LSB_FIRST=0, SI=1, load PI=4'b0110 -> O sequence 0,1,1,0. Internal shreg ends at 4'b1111 before returning to IDLE.
- Back-to-back: WIDTH=4, load 0x3, then hold VALID=1 with PI=0xC -> READY pulses only on the last-bit CE edge, coincident with DONE. O goes 1,1,0,0 then 0,0,1,1 with no IDLE_LEVEL cycle in between.
- Ignored events:
  - CE pulses while IDLE -> no change to COUNT or O.
  - VALID asserted mid-word with PI=0xFF -> READY stays 0 and the word in flight is unaltered.
- Reset mid-word: WIDTH=8, assert RESETN=0 after 3 CEs -> outputs take their reset values immediately with no DONE pulse. A reload after release sends the new word from bit 0.
